snake_step_ctrl: RTL and testbench
==================================

# snake_step_ctrl

Sequencing controller for the snake game. It owns the snake body and the direction, and generates the frame step tick. On every tick it computes the next head cell, checks for wall and self collision, and issues cell write commands to the game-field store. It sits between the button and grow inputs and the field and 7-segment display logic, and replaces the event-triggered debug moves with a clocked, one-write-per-cycle sequence.

## Interface
Parameters:
- GRID_W, 8: field columns; x range 0..GRID_W-1.
- GRID_H, 4: field rows; y range 0..GRID_H-1.
- MAX_LEN, 8: maximum snake length in segments.
- TICK_DIV, 50_000_000: clock cycles per step. Must satisfy TICK_DIV > MAX_LEN+4.

Ports:
- clk, in, 1: the single clock. Reset is synchronous and active-low.
- rst_n, in, 1: synchronous active-low reset.
- start, in, 1: pulse. Initializes and starts a game when not running.
- turn_l, in, 1: pulse. Rotate direction counter-clockwise.
- turn_r, in, 1: pulse. Rotate direction clockwise.
- grow, in, 1: pulse. Lengthen the snake by one at the next step.
- field_clr, out, 1: one-cycle pulse telling the field store to clear all cells.
- field_we, out, 1: cell write strobe.
- field_x, out, $clog2(GRID_W): cell x coordinate for the write.
- field_y, out, $clog2(GRID_H): cell y coordinate for the write.
- field_val, out, 1: value written; 1 = segment lit, 0 = clear.
- head_x, out, $clog2(GRID_W): current head x.
- head_y, out, $clog2(GRID_H): current head y.
- dir, out, 2: current direction. 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
- length, out, $clog2(MAX_LEN+1): current snake length.
- running, out, 1: a game is in progress.
- game_over, out, 1: sticky flag, cleared by start.

## Operation
- **Reset values:** running=0, game_over=0, field_we=0, field_clr=0, field_val=0, field_x=0, field_y=0, head=(0,0), dir=01, length=1. FSM is in IDLE, tick counter is 0, and the turn and grow latches are clear.
- **FSM states:** IDLE, INIT, CALC, CHECK, ERASE, DRAW.
- **IDLE:**
  - start while running=0 goes to INIT.
  - A step tick while running=1 goes to CALC.
  - start while running=1 is ignored.
- **INIT:**
  - Pulses field_clr.
  - Resets body to a single segment at (0,0), dir=01, length=1.
  - Clears game_over and sets running=1.
  - Goes to DRAW to light (0,0).
- **CALC:**
  - Applies the latched turn to dir: turn_r adds 1 mod 4, turn_l subtracts 1 mod 4.
  - Computes the next head.
  - If the next head is outside the grid, the step aborts: game_over=1, running=0, no field writes, back to IDLE.
  - Otherwise goes to CHECK.
- **CHECK:**
  - Compares the next head against one body segment per cycle, tail to head.
  - The tail segment is excluded unless a grow is pending, because the tail vacates on this step.
  - On a match: game_over=1, running=0, no field writes, IDLE.
  - With no match, goes to ERASE, or straight to DRAW when growing.
- **ERASE:** field_we=1, val=0 at the tail cell, then pops the tail.
- **DRAW:**
  - field_we=1, val=1 at the next head cell.
  - Pushes the new head, updates head_x/head_y and length (growth applied here), clears the grow latch, returns to IDLE.
- **Turn latch:**
  - Only the first turn pulse after the previous CALC is kept; later pulses are ignored until the next CALC.
  - turn_l and turn_r asserted in the same cycle are both ignored.
- **Grow:**
  - The grow pulse sets a pending flag.
  - At length==MAX_LEN, growth is discarded and the step proceeds as a normal move.
- **Tick counter:**
  - Free-runs 0..TICK_DIV-1 only while running=1 and is held at 0 otherwise.
  - A tick is the cycle in which the count wraps.
  - A tick arriving outside IDLE is dropped.
- **Inputs while not running:** turns and grow are ignored.

## Timing
- Tick to DRAW write: 2+N cycles, where N is the number of CHECK compares. Add 1 cycle when ERASE is used.
- field_we is high for exactly one cycle per write, with at most 2 writes per step.
- head_x, head_y and length update on the clock edge ending DRAW.
- game_over asserts on the edge ending CALC or the matching CHECK cycle.
- start to the first field_we is 2 cycles (INIT, then DRAW).
- **Reset mid-operation:** rst_n low at any edge forces all reset values at that edge. No write is issued after it.

## Structure
- Package snake_pkg holds:
  - dir_t with DIR_UP/RIGHT/DOWN/LEFT.
  - The FSM state enum.
  - Helper function next_cell(x, y, dir).
- Sub-module snake_body_buf is a circular buffer of MAX_LEN (x,y) entries with push_head, pop_tail, an indexed read port and count.

## Test plan
Bench parameters: GRID_W=8, GRID_H=4, MAX_LEN=8, TICK_DIV=16.

1. **Reset, start, first step.** Reset, then start. Required: field_clr, then write (0,0,1). Next tick: write (0,0,0), then (1,0,1); head=(1,0), length=1.
2. **Single turn.** turn_r before a tick, head at (1,0). Required: dir=10, head=(1,1). turn_l+turn_r in the same cycle, then a tick: dir unchanged. Two turn_r in one step: dir advances once only.
3. **Wall hit.** Run right from (0,0) for 8 ticks. Required: the 8th tick sets game_over=1, running=0, with no field_we; head stays (7,0).
4. **Self hit.** Grow to length 5 with head (5,0), then turn_r before each of 3 ticks. Required: moves to (5,1), then (4,1). The third step targets (4,0), which is still body, so game_over=1 and no writes.
5. **Grow saturation.** At length 8, pulse grow, then a tick. Required: length stays 8 and both ERASE and DRAW writes occur.
6. **Reset mid-step.** rst_n=0 during CHECK. Required: all outputs take reset values at that edge, and field_we stays 0 afterwards.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake step controller.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CALC,
    ST_CHECK,
    ST_ERASE,
    ST_DRAW
  } state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } cell_t;

  // Stepping off the low edge wraps to 16'hFFFF, so a single unsigned
  // compare against the grid size catches both walls.
  function automatic cell_t next_cell(input logic [15:0] x, input logic [15:0] y,
                                      input dir_t d);
    cell_t c;
    c.x = x;
    c.y = y;
    case (d)
      DIR_UP:    c.y = y - 16'd1;
      DIR_RIGHT: c.x = x + 16'd1;
      DIR_DOWN:  c.y = y + 16'd1;
      default:   c.x = x - 16'd1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/snake_body_buf.sv
// Circular buffer of snake segments; index 0 of the read port is the tail.
module snake_body_buf
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int XW      = 3,
  parameter int YW      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         init,
  input  logic                         push,
  input  logic [XW-1:0]                push_x,
  input  logic [YW-1:0]                push_y,
  input  logic                         pop,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
  output logic [XW-1:0]                rd_x,
  output logic [YW-1:0]                rd_y,
  output logic [$clog2(MAX_LEN+1)-1:0] count
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int SW = CW + 1;

  logic [XW-1:0] mem_x [MAX_LEN];
  logic [YW-1:0] mem_y [MAX_LEN];
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [CW-1:0] off);
    logic [SW-1:0] sum;
    sum = SW'(base) + SW'(off);
    if (sum >= SW'(MAX_LEN)) sum = sum - SW'(MAX_LEN);
    return PW'(sum);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (pop) tail <= wrap_add(tail, CW'(1));
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // New head lands just past the newest entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wrap_add(tail, cnt)] <= push_x;
      mem_y[wrap_add(tail, cnt)] <= push_y;
    end
  end

  assign rd_x  = mem_x[wrap_add(tail, CW'(rd_idx))];
  assign rd_y  = mem_y[wrap_add(tail, CW'(rd_idx))];
  assign count = cnt;

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake step sequencer: tick generation, turn/grow latching, collision
// checks and one-write-per-cycle field updates.
//
// state  | meaning
// IDLE   | waiting for start (stopped) or a step tick (running)
// INIT   | clear field, reset body/dir/length, set running
// CALC   | apply latched turn, compute next head, wall check
// CHECK  | compare next head against one body segment per cycle
// ERASE  | clear tail cell, pop tail
// DRAW   | light next head cell, push head, update length
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W   = 8,
  parameter int GRID_H   = 4,
  parameter int MAX_LEN  = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         turn_l,
  input  logic                         turn_r,
  input  logic                         grow,
  output logic                         field_clr,
  output logic                         field_we,
  output logic [$clog2(GRID_W)-1:0]    field_x,
  output logic [$clog2(GRID_H)-1:0]    field_y,
  output logic                         field_val,
  output logic [$clog2(GRID_W)-1:0]    head_x,
  output logic [$clog2(GRID_H)-1:0]    head_y,
  output logic [1:0]                   dir,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         running,
  output logic                         game_over
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TICK_DIV);

  state_t        state, state_nx;
  logic [TW-1:0] cnt;
  logic          tick;
  logic          turn_vld, turn_cw;
  logic          grow_pend, grow_step, grow_eff;
  dir_t          dir_q, dir_new;
  logic [XW-1:0] head_x_q, nx_q, rd_x;
  logic [YW-1:0] head_y_q, ny_q, rd_y;
  logic [CW-1:0] len_q, chk_idx, buf_cnt;
  logic          running_q, game_over_q;
  cell_t         nc;
  logic          wall, hit, chk_last, abort;

  assign tick     = running_q && (cnt == TW'(TICK_DIV - 1));
  assign grow_eff = grow_pend && (len_q < CW'(MAX_LEN));
  assign nc       = next_cell(16'(head_x_q), 16'(head_y_q), dir_new);
  assign wall     = (nc.x >= 16'(GRID_W)) || (nc.y >= 16'(GRID_H));
  assign hit      = (rd_x == nx_q) && (rd_y == ny_q);
  assign chk_last = (chk_idx == buf_cnt - CW'(1));
  assign abort    = ((state == ST_CALC) && wall) || ((state == ST_CHECK) && hit);

  always_comb begin
    dir_new = dir_q;
    if (turn_vld) dir_new = turn_cw ? dir_t'(dir_q + 2'd1) : dir_t'(dir_q - 2'd1);
  end

  snake_body_buf #(
    .MAX_LEN(MAX_LEN),
    .XW     (XW),
    .YW     (YW)
  ) u_body (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (state == ST_INIT),
    .push  (state == ST_DRAW),
    .push_x(nx_q),
    .push_y(ny_q),
    .pop   (state == ST_ERASE),
    .rd_idx((state == ST_ERASE) ? '0 : PW'(chk_idx)),
    .rd_x  (rd_x),
    .rd_y  (rd_y),
    .count (buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    field_clr = 1'b0;
    field_we  = 1'b0;
    field_x   = '0;
    field_y   = '0;
    field_val = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !running_q) state_nx = ST_INIT;
        else if (tick)           state_nx = ST_CALC;
      end
      ST_INIT: begin
        field_clr = 1'b1;
        state_nx  = ST_DRAW;
      end
      ST_CALC: begin
        if (wall)                               state_nx = ST_IDLE;
        else if (!grow_eff && buf_cnt == CW'(1)) state_nx = ST_ERASE;
        else                                    state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (hit)           state_nx = ST_IDLE;
        else if (chk_last) state_nx = grow_step ? ST_DRAW : ST_ERASE;
      end
      ST_ERASE: begin
        field_we = 1'b1;
        field_x  = rd_x;
        field_y  = rd_y;
        state_nx = ST_DRAW;
      end
      ST_DRAW: begin
        field_we  = 1'b1;
        field_x   = nx_q;
        field_y   = ny_q;
        field_val = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      turn_vld    <= 1'b0;
      turn_cw     <= 1'b0;
      grow_pend   <= 1'b0;
      grow_step   <= 1'b0;
      dir_q       <= DIR_RIGHT;
      head_x_q    <= '0;
      head_y_q    <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      len_q       <= CW'(1);
      chk_idx     <= '0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      if (!running_q || tick) cnt <= '0;
      else                    cnt <= cnt + TW'(1);

      // Only the first clean turn since the last CALC is kept.
      if (state == ST_CALC || abort) turn_vld <= 1'b0;
      else if (running_q && !turn_vld && (turn_l ^ turn_r)) begin
        turn_vld <= 1'b1;
        turn_cw  <= turn_r;
      end

      if (abort || state == ST_DRAW) grow_pend <= 1'b0;
      else if (running_q && grow)    grow_pend <= 1'b1;

      case (state)
        ST_INIT: begin
          dir_q       <= DIR_RIGHT;
          head_x_q    <= '0;
          head_y_q    <= '0;
          nx_q        <= '0;
          ny_q        <= '0;
          len_q       <= CW'(1);
          grow_step   <= 1'b0;
          running_q   <= 1'b1;
          game_over_q <= 1'b0;
        end
        ST_CALC: begin
          dir_q <= dir_new;
          if (wall) begin
            game_over_q <= 1'b1;
            running_q   <= 1'b0;
          end else begin
            nx_q      <= nc.x[XW-1:0];
            ny_q      <= nc.y[YW-1:0];
            grow_step <= grow_eff;
            // The tail vacates on a plain move, so skip comparing it.
            chk_idx   <= grow_eff ? '0 : CW'(1);
          end
        end
        ST_CHECK: begin
          if (hit) begin
            game_over_q <= 1'b1;
            running_q   <= 1'b0;
          end else begin
            chk_idx <= chk_idx + CW'(1);
          end
        end
        ST_DRAW: begin
          head_x_q <= nx_q;
          head_y_q <= ny_q;
          len_q    <= len_q + CW'(grow_step);
        end
        default: ;
      endcase
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign dir       = dir_q;
  assign length    = len_q;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl on an 8x4 field with a 16-cycle step.
module tb_snake_step_ctrl;
  localparam int GRID_W   = 8;
  localparam int GRID_H   = 4;
  localparam int MAX_LEN  = 8;
  localparam int TICK_DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, turn_l = 1'b0, turn_r = 1'b0, grow = 1'b0;
  logic       field_clr, field_we, field_val;
  logic [2:0] field_x, head_x;
  logic [1:0] field_y, head_y, dir;
  logic [3:0] length;
  logic       running, game_over;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snake_step_ctrl #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .MAX_LEN (MAX_LEN),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .turn_l   (turn_l),
    .turn_r   (turn_r),
    .grow     (grow),
    .field_clr(field_clr),
    .field_we (field_we),
    .field_x  (field_x),
    .field_y  (field_y),
    .field_val(field_val),
    .head_x   (head_x),
    .head_y   (head_y),
    .dir      (dir),
    .length   (length),
    .running  (running),
    .game_over(game_over)
  );

  function automatic logic [5:0] cellv(input int x, input int y, input int v);
    return {3'(x), 2'(y), 1'(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int hx, input int hy, input int d,
                              input int len, input int go, input int run);
    chk({tag, ":head_x"}, 32'(head_x), hx);
    chk({tag, ":head_y"}, 32'(head_y), hy);
    chk({tag, ":dir"}, 32'(dir), d);
    chk({tag, ":length"}, 32'(length), len);
    chk({tag, ":game_over"}, 32'(game_over), go);
    chk({tag, ":running"}, 32'(running), run);
  endtask

  // One-cycle input pulse, driven from a falling edge.
  task automatic pulse(input bit l, input bit r, input bit g, input bit s);
    turn_l = l; turn_r = r; grow = g; start = s;
    @(negedge clk);
    turn_l = 1'b0; turn_r = 1'b0; grow = 1'b0; start = 1'b0;
  endtask

  task automatic do_start(input string tag);
    pulse(0, 0, 0, 1);
    chk({tag, ":init_clr"}, 32'(field_clr), 1);
    chk({tag, ":init_we"}, 32'(field_we), 0);
    @(negedge clk);
    chk({tag, ":draw_we"}, 32'(field_we), 1);
    chk({tag, ":draw_cell"}, 32'({field_x, field_y, field_val}), 32'(cellv(0, 0, 1)));
    @(negedge clk);
    expect_state({tag, ":started"}, 0, 0, 1, 1, 0, 1);
  endtask

  // Waits for the next step to end (DRAW write or game over) and records writes.
  task automatic run_step(output int nw, output logic [5:0] w0, output logic [5:0] w1);
    bit done;
    nw = 0; w0 = '0; w1 = '0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (field_we) begin
        if (nw == 0) w0 = {field_x, field_y, field_val};
        else         w1 = {field_x, field_y, field_val};
        nw++;
        if (field_val) done = 1'b1;
      end
      if (game_over) done = 1'b1;
    end
    if (!done) chk("step_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int nw, we_seen;
    logic [5:0] w0, w1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_state("reset", 0, 0, 1, 1, 0, 0);
    chk("reset:we", 32'(field_we), 0);
    chk("reset:clr", 32'(field_clr), 0);
    chk("reset:cell", 32'({field_x, field_y, field_val}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start and first step
    do_start("t1");
    run_step(nw, w0, w1);
    chk("t1_step:nw", nw, 2);
    chk("t1_step:erase", 32'(w0), 32'(cellv(0, 0, 0)));
    chk("t1_step:draw", 32'(w1), 32'(cellv(1, 0, 1)));
    expect_state("t1_step", 1, 0, 1, 1, 0, 1);

    // Turns
    pulse(0, 1, 0, 0);
    run_step(nw, w0, w1);
    chk("t2_turn_r:erase", 32'(w0), 32'(cellv(1, 0, 0)));
    expect_state("t2_turn_r", 1, 1, 2, 1, 0, 1);
    pulse(1, 1, 0, 0);
    run_step(nw, w0, w1);
    expect_state("t2_both", 1, 2, 2, 1, 0, 1);
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    run_step(nw, w0, w1);
    expect_state("t2_double", 0, 2, 3, 1, 0, 1);

    // Left wall, then inputs ignored while stopped
    run_step(nw, w0, w1);
    chk("t3_left_wall:nw", nw, 0);
    expect_state("t3_left_wall", 0, 2, 3, 1, 1, 0);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    do_start("t3");
    run_step(nw, w0, w1);
    chk("t3_idle_ignored:nw", nw, 2);
    expect_state("t3_idle_ignored", 1, 0, 1, 1, 0, 1);

    // Right wall on the 8th tick; start while running is ignored
    for (int i = 2; i <= 7; i++) begin
      if (i == 4) begin
        pulse(0, 0, 0, 1);
        chk("t3_start_ignored:clr", 32'(field_clr), 0);
        @(negedge clk);
        chk("t3_start_ignored:we", 32'(field_we), 0);
      end
      run_step(nw, w0, w1);
      chk($sformatf("t3_run%0d:nw", i), nw, 2);
      expect_state($sformatf("t3_run%0d", i), i, 0, 1, 1, 0, 1);
    end
    run_step(nw, w0, w1);
    chk("t3_right_wall:nw", nw, 0);
    expect_state("t3_right_wall", 7, 0, 1, 1, 1, 0);

    // Self hit
    do_start("t4");
    for (int i = 1; i <= 4; i++) begin
      pulse(0, 0, 1, 0);
      run_step(nw, w0, w1);
      chk($sformatf("t4_grow%0d:nw", i), nw, 1);
      expect_state($sformatf("t4_grow%0d", i), i, 0, 1, i + 1, 0, 1);
    end
    run_step(nw, w0, w1);
    chk("t4_move:nw", nw, 2);
    expect_state("t4_move", 5, 0, 1, 5, 0, 1);
    pulse(0, 1, 0, 0);
    run_step(nw, w0, w1);
    chk("t4_down:erase", 32'(w0), 32'(cellv(1, 0, 0)));
    expect_state("t4_down", 5, 1, 2, 5, 0, 1);
    pulse(0, 1, 0, 0);
    run_step(nw, w0, w1);
    expect_state("t4_left", 4, 1, 3, 5, 0, 1);
    pulse(0, 1, 0, 0);
    run_step(nw, w0, w1);
    chk("t4_hit:nw", nw, 0);
    expect_state("t4_hit", 4, 1, 0, 5, 1, 0);

    // Moving into the tail: legal on a plain move, a hit when growing
    do_start("tl");
    pulse(0, 0, 1, 0);
    run_step(nw, w0, w1);
    expect_state("tl_a", 1, 0, 1, 2, 0, 1);
    pulse(0, 1, 1, 0);
    run_step(nw, w0, w1);
    expect_state("tl_b", 1, 1, 2, 3, 0, 1);
    pulse(0, 1, 1, 0);
    run_step(nw, w0, w1);
    expect_state("tl_c", 0, 1, 3, 4, 0, 1);
    pulse(0, 1, 0, 0);
    run_step(nw, w0, w1);
    chk("tl_into_tail:nw", nw, 2);
    chk("tl_into_tail:erase", 32'(w0), 32'(cellv(0, 0, 0)));
    chk("tl_into_tail:draw", 32'(w1), 32'(cellv(0, 0, 1)));
    expect_state("tl_into_tail", 0, 0, 0, 4, 0, 1);
    pulse(0, 1, 1, 0);
    run_step(nw, w0, w1);
    chk("tl_grow_tail:nw", nw, 0);
    expect_state("tl_grow_tail", 0, 0, 1, 4, 1, 0);

    // Grow saturation at MAX_LEN
    do_start("t5");
    for (int i = 1; i <= 7; i++) begin
      pulse(0, 0, 1, 0);
      run_step(nw, w0, w1);
      expect_state($sformatf("t5_grow%0d", i), i, 0, 1, i + 1, 0, 1);
    end
    pulse(0, 1, 1, 0);
    run_step(nw, w0, w1);
    chk("t5_sat:nw", nw, 2);
    chk("t5_sat:erase", 32'(w0), 32'(cellv(0, 0, 0)));
    chk("t5_sat:draw", 32'(w1), 32'(cellv(7, 1, 1)));
    expect_state("t5_sat", 7, 1, 2, 8, 0, 1);

    // Reset during CHECK of the next step (8 compares window)
    we_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (field_we) we_seen++;
    end
    chk("t6_pre:we", we_seen, 0);
    rst_n = 1'b0;
    @(negedge clk);
    expect_state("t6_reset", 0, 0, 1, 1, 0, 0);
    chk("t6_reset:we", 32'(field_we), 0);
    chk("t6_reset:clr", 32'(field_clr), 0);
    chk("t6_reset:cell", 32'({field_x, field_y, field_val}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    we_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (field_we || field_clr) we_seen++;
    end
    chk("t6_after:we", we_seen, 0);
    chk("t6_after:running", 32'(running), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
